// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NPC_W_DEF = 4;
  localparam int unsigned IMM16_W   = 16;
  localparam int unsigned IMM26_W   = 26;

  localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

  // Next-PC operation codes produced by the main control decoder.
  localparam int unsigned NPC_PLUS4  = 0;
  localparam int unsigned NPC_BRANCH = 1;
  localparam int unsigned NPC_JUMP   = 2;
  localparam int unsigned NPC_JR     = 3;
  localparam int unsigned NPC_JALR   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  // One buffered instruction together with its byte address.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem req/ack, decode valid/ready and redirect inputs.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned NPC_W = NPC_W_DEF
);

  logic                 imem_req;
  logic [XLEN-1:0]      imem_addr;
  logic                 imem_ack;
  logic [XLEN-1:0]      imem_rdata;

  logic                 inst_valid;
  logic [XLEN-1:0]      inst;
  logic [XLEN-1:0]      inst_pc;
  logic                 inst_ready;

  logic                 redir_valid;
  logic [NPC_W-1:0]     npc_op;
  logic [XLEN-1:0]      redir_pc;
  logic [IMM16_W-1:0]   imm16;
  logic [IMM26_W-1:0]   imm26;
  logic [XLEN-1:0]      rs_data;

  logic                 align_err;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, align_err,
    input  imem_ack, imem_rdata, inst_ready,
    input  redir_valid, npc_op, redir_pc, imm16, imm26, rs_data
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, align_err,
    output imem_ack, imem_rdata, inst_ready,
    output redir_valid, npc_op, redir_pc, imm16, imm26, rs_data
  );

endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Combinational redirect target calculator for BRANCH/JUMP/JR/JALR.
module npc_calc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned NPC_W = NPC_W_DEF
) (
  input  logic [NPC_W-1:0]   npc_op,
  input  logic [XLEN-1:0]    redir_pc,
  input  logic [IMM16_W-1:0] imm16,
  input  logic [IMM26_W-1:0] imm26,
  input  logic [XLEN-1:0]    rs_data,
  output logic [XLEN-1:0]    target,
  output logic               taken,
  output logic               misalign
);

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_off;

  always_comb begin
    seq_pc   = redir_pc + XLEN'(4);
    br_off   = {{(XLEN-IMM16_W-2){imm16[IMM16_W-1]}}, imm16, 2'b00};
    target   = seq_pc;
    taken    = 1'b0;
    misalign = 1'b0;
    case (npc_op)
      NPC_W'(NPC_PLUS4): begin
        taken = 1'b0;
      end
      NPC_W'(NPC_BRANCH): begin
        target = seq_pc + br_off;
        taken  = 1'b1;
      end
      NPC_W'(NPC_JUMP): begin
        target = {seq_pc[XLEN-1:XLEN-4], imm26, 2'b00};
        taken  = 1'b1;
      end
      NPC_W'(NPC_JR), NPC_W'(NPC_JALR): begin
        // Register targets are force-aligned; the low bits only flag an error.
        target   = {rs_data[XLEN-1:2], 2'b00};
        taken    = 1'b1;
        misalign = |rs_data[1:0];
      end
      default: begin
        taken = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem fetch outstanding at a
// time and presents a single buffered instruction to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned     NPC_W    = NPC_W_DEF
) (
  input logic          clk,
  input logic          rstn,
  fetch_unit_if.master bus
);

  localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  fetch_pkt_t      pkt_q, pkt_d;
  logic            drop_q, drop_d;
  logic            align_q, align_d;

  logic [XLEN-1:0] target;
  logic            taken;
  logic            misalign;
  logic            redir;

  npc_calc #(.NPC_W(NPC_W)) u_npc_calc (
    .npc_op   (bus.npc_op),
    .redir_pc (bus.redir_pc),
    .imm16    (bus.imm16),
    .imm26    (bus.imm26),
    .rs_data  (bus.rs_data),
    .target   (target),
    .taken    (taken),
    .misalign (misalign)
  );

  assign redir = bus.redir_valid & taken;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_AL;
      addr_q  <= RESET_PC_AL;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      pkt_q   <= '0;
      drop_q  <= 1'b0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      drop_q  <= drop_d;
      align_q <= align_d;
    end
  end

  // Next-state logic; a redirect is applied last so it overrides everything.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    valid_d = valid_q;
    pkt_d   = pkt_q;
    drop_d  = drop_q;
    align_d = bus.redir_valid & misalign;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        req_d   = 1'b1;
        addr_d  = pc_q;
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (drop_q) begin
            drop_d = 1'b0;
            addr_d = pc_q;
          end else begin
            pkt_d.inst = bus.imem_rdata;
            pkt_d.pc   = addr_q;
            valid_d    = 1'b1;
            pc_d       = addr_q + XLEN'(4);
            req_d      = 1'b0;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (valid_q && bus.inst_ready) begin
          valid_d = 1'b0;
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = REQ;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (redir) begin
      pc_d    = target;
      valid_d = 1'b0;
      pkt_d   = pkt_q;
      state_d = REQ;
      req_d   = 1'b1;
      // An unanswered request must stay up; its data is discarded on arrival.
      if (state_q == REQ && !bus.imem_ack) begin
        drop_d = 1'b1;
        addr_d = addr_q;
      end else begin
        drop_d = 1'b0;
        addr_d = target;
      end
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = addr_q;
  assign bus.inst_valid = valid_q;
  assign bus.inst       = pkt_q.inst;
  assign bus.inst_pc    = pkt_q.pc;
  assign bus.align_err  = align_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a redirect vector table and a
// randomized run against a PC-stream reference model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fetch_unit_if #(.NPC_W(4)) bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NPC_W(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  int mem_lat  = 1;
  bit rand_lat = 1'b0;
  int mem_cnt  = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rpc;
    logic [15:0] i16;
    logic [25:0] i26;
    logic [31:0] rs;
    logic        rdy;
    logic        taken;
    logic [31:0] tgt;
    logic        mis;
  } vec_t;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] ref_target(input logic [3:0] op, input logic [31:0] rpc,
                                             input logic [15:0] i16, input logic [25:0] i26,
                                             input logic [31:0] rs);
    int off;
    off = int'($signed(i16)) * 4;
    case (op)
      4'd1:    return rpc + 32'd4 + 32'(off);
      4'd2:    return ((rpc + 32'd4) & 32'hF000_0000) | (32'(i26) * 32'd4);
      default: return rs & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory: acks mem_lat cycles after the request is first seen, one-cycle ack.
  always @(negedge clk) begin
    if (!rstn) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
      mem_cnt        = 0;
    end else begin
      if (bus.imem_ack) begin
        bus.imem_ack = 1'b0;
        mem_cnt      = 0;
      end
      if (!bus.imem_req) begin
        mem_cnt = 0;
      end else begin
        mem_cnt++;
        if (mem_cnt > mem_lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem_data(bus.imem_addr);
          if (rand_lat) mem_lat = $urandom_range(1, 4);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_ready  = 1'b0;
    bus.redir_valid = 1'b0;
    bus.npc_op      = '0;
    bus.redir_pc    = '0;
    bus.imm16       = '0;
    bus.imm26       = '0;
    bus.rs_data     = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_inputs();
    repeat (2) cyc();
    rstn = 1'b1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!bus.inst_valid && n < 60) begin
      cyc();
      n++;
    end
    if (!bus.inst_valid) chk("wait_valid_timeout", 32'(bus.inst_valid), 32'd1);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 60) begin
      cyc();
      n++;
    end
    if (!bus.imem_req) chk("wait_req_timeout", 32'(bus.imem_req), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
    chk({tag, "_valid"}, 32'(bus.inst_valid), 32'd0);
    chk({tag, "_inst"},  bus.inst, 32'd0);
    chk({tag, "_ipc"},   bus.inst_pc, 32'd0);
    chk({tag, "_align"}, 32'(bus.align_err), 32'd0);
  endtask

  // Ready tied high, 1-cycle memory: addresses 0,4,8 and 2-cycle first latency.
  task automatic seq_basic();
    int first_req = -1;
    int first_val = -1;
    int n_acc = 0;
    int n_del = 0;
    logic [31:0] acc [3];
    logic [31:0] del [3];
    for (int i = 0; i < 3; i++) begin
      acc[i] = 32'hFFFF_FFFF;
      del[i] = 32'hFFFF_FFFF;
    end
    bus.inst_ready = 1'b1;
    for (int c = 0; c < 40 && n_del < 3; c++) begin
      cyc();
      if (bus.imem_req && first_req < 0) first_req = c;
      if (bus.inst_valid && first_val < 0) first_val = c;
      if (bus.imem_req && bus.imem_ack && n_acc < 3) begin
        acc[n_acc] = bus.imem_addr;
        n_acc++;
      end
      if (bus.inst_valid && bus.inst_ready && n_del < 3) begin
        del[n_del] = bus.inst_pc;
        chk("basic_inst", bus.inst, mem_data(bus.inst_pc));
        n_del++;
      end
    end
    chk("basic_first_lat", 32'(first_val - first_req), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("basic_addr", acc[i], 32'(4 * i));
      chk("basic_inst_pc", del[i], 32'(4 * i));
    end
  endtask

  // Decode stalls five cycles: no new request, buffered data held stable.
  task automatic seq_stall();
    logic [31:0] s_inst;
    logic [31:0] s_pc;
    bus.inst_ready = 1'b0;
    wait_valid();
    s_inst = bus.inst;
    s_pc   = bus.inst_pc;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_valid", 32'(bus.inst_valid), 32'd1);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      chk("stall_inst", bus.inst, s_inst);
      chk("stall_ipc", bus.inst_pc, s_pc);
    end
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    chk("stall_release_valid", 32'(bus.inst_valid), 32'd0);
    chk("stall_release_req", 32'(bus.imem_req), 32'd1);
    chk("stall_release_addr", bus.imem_addr, s_pc + 32'd4);
  endtask

  // Redirect vectors applied while an instruction sits in the buffer.
  task automatic seq_table();
    vec_t tv [12];
    logic [31:0] snap;
    tv[0]  = '{4'd1, 32'h0000_0100, 16'hFFFE, 26'h0,        32'h0,         1'b0, 1'b1, 32'h0000_00FC, 1'b0};
    tv[1]  = '{4'd2, 32'h3000_0010, 16'h0,    26'h000_0040, 32'h0,         1'b1, 1'b1, 32'h3000_0100, 1'b0};
    tv[2]  = '{4'd3, 32'h0000_0040, 16'h0,    26'h0,        32'h0000_2003, 1'b0, 1'b1, 32'h0000_2000, 1'b1};
    tv[3]  = '{4'd4, 32'h0000_0040, 16'h0,    26'h0,        32'h0000_1234, 1'b1, 1'b1, 32'h0000_1234, 1'b0};
    tv[4]  = '{4'd1, 32'h0000_0200, 16'h0010, 26'h0,        32'h0,         1'b0, 1'b1, 32'h0000_0244, 1'b0};
    tv[5]  = '{4'd0, 32'h0000_0200, 16'h0010, 26'h1,        32'h0000_0003, 1'b0, 1'b0, 32'h0,         1'b0};
    tv[6]  = '{4'd7, 32'h0000_0300, 16'h0004, 26'h2,        32'h0000_0001, 1'b1, 1'b0, 32'h0,         1'b0};
    tv[7]  = '{4'd2, 32'hFFFF_FFFC, 16'h0,    26'h3FF_FFFF, 32'h0,         1'b0, 1'b1, 32'h0FFF_FFFC, 1'b0};
    tv[8]  = '{4'd1, 32'hFFFF_FFF0, 16'h7FFF, 26'h0,        32'h0,         1'b0, 1'b1, 32'h0001_FFF0, 1'b0};
    tv[9]  = '{4'd4, 32'h0000_0000, 16'h0,    26'h0,        32'h8000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b1};
    tv[10] = '{4'd15, 32'h0000_0500, 16'h0,   26'h0,        32'h0000_0002, 1'b0, 1'b0, 32'h0,         1'b0};
    tv[11] = '{4'd1, 32'h0000_0000, 16'h8000, 26'h0,        32'h0,         1'b0, 1'b1, 32'hFFFE_0004, 1'b0};
    for (int i = 0; i < 12; i++) begin
      bus.inst_ready = 1'b0;
      wait_valid();
      snap            = bus.inst_pc;
      bus.redir_valid = 1'b1;
      bus.npc_op      = tv[i].op;
      bus.redir_pc    = tv[i].rpc;
      bus.imm16       = tv[i].i16;
      bus.imm26       = tv[i].i26;
      bus.rs_data     = tv[i].rs;
      bus.inst_ready  = tv[i].rdy;
      cyc();
      bus.redir_valid = 1'b0;
      bus.inst_ready  = 1'b0;
      chk("tv_align", 32'(bus.align_err), 32'(tv[i].mis));
      if (tv[i].taken) begin
        chk("tv_flush", 32'(bus.inst_valid), 32'd0);
        chk("tv_req", 32'(bus.imem_req), 32'd1);
        chk("tv_target", bus.imem_addr, tv[i].tgt);
      end else if (tv[i].rdy) begin
        chk("tv_nt_valid", 32'(bus.inst_valid), 32'd0);
        chk("tv_nt_req", 32'(bus.imem_req), 32'd1);
        chk("tv_nt_addr", bus.imem_addr, snap + 32'd4);
      end else begin
        chk("tv_nt_hold", 32'(bus.inst_valid), 32'd1);
        chk("tv_nt_noreq", 32'(bus.imem_req), 32'd0);
        chk("tv_nt_ipc", bus.inst_pc, snap);
      end
    end
  endtask

  // Misaligned JR while a slow fetch is outstanding: late data must be dropped.
  task automatic seq_jr_late();
    logic [31:0] old;
    int pulses;
    bit early_valid;
    bit moved;
    bus.inst_ready = 1'b0;
    wait_valid();
    mem_lat        = 3;
    old            = bus.inst_pc + 32'd4;
    bus.inst_ready = 1'b1;
    cyc();
    bus.inst_ready = 1'b0;
    chk("jr_req_up", 32'(bus.imem_req), 32'd1);
    chk("jr_req_addr", bus.imem_addr, old);
    bus.redir_valid = 1'b1;
    bus.npc_op      = 4'd3;
    bus.rs_data     = 32'h0000_2003;
    cyc();
    bus.redir_valid = 1'b0;
    chk("jr_align_pulse", 32'(bus.align_err), 32'd1);
    chk("jr_req_kept", 32'(bus.imem_req), 32'd1);
    chk("jr_addr_kept", bus.imem_addr, old);
    pulses      = 1;
    early_valid = 1'b0;
    moved       = 1'b0;
    for (int c = 0; c < 20 && !moved; c++) begin
      cyc();
      if (bus.align_err) pulses++;
      if (bus.inst_valid) early_valid = 1'b1;
      if (bus.imem_req && bus.imem_addr != old) moved = 1'b1;
    end
    chk("jr_align_once", 32'(pulses), 32'd1);
    chk("jr_no_late_data", 32'(early_valid), 32'd0);
    chk("jr_new_addr", bus.imem_addr, 32'h0000_2000);
    wait_valid();
    chk("jr_first_ipc", bus.inst_pc, 32'h0000_2000);
    chk("jr_first_inst", bus.inst, mem_data(32'h0000_2000));
  endtask

  // Reset asserted while a request is waiting for its ack.
  task automatic seq_reset_mid();
    mem_lat        = 3;
    bus.inst_ready = 1'b1;
    wait_req();
    chk("rstmid_in_req", 32'(bus.imem_req), 32'd1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("rstmid");
    repeat (2) cyc();
    mem_lat = 1;
    rstn    = 1'b1;
    wait_req();
    chk("rstmid_restart_addr", bus.imem_addr, 32'h0000_0000);
    wait_valid();
    chk("rstmid_restart_ipc", bus.inst_pc, 32'h0000_0000);
  endtask

  // Random ready/redirects/latency against a model of the delivered PC stream.
  task automatic seq_random();
    logic [31:0] exp_pc;
    logic        exp_al;
    int          consumed;
    logic        eff;
    logic        p_req, p_ack, p_valid, p_rdy, p_eff;
    logic [31:0] p_addr, p_inst, p_ipc;
    do_reset();
    rand_lat = 1'b1;
    exp_pc   = 32'h0;
    exp_al   = 1'b0;
    consumed = 0;
    p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_rdy = 1'b0; p_eff = 1'b0;
    p_addr = '0; p_inst = '0; p_ipc = '0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      bus.inst_ready  = ($urandom_range(0, 9) < 6);
      bus.redir_valid = ($urandom_range(0, 99) < 8);
      bus.npc_op      = 4'($urandom_range(0, 7));
      bus.redir_pc    = $urandom() & 32'hFFFF_FFFC;
      bus.imm16       = 16'($urandom());
      bus.imm26       = 26'($urandom());
      bus.rs_data     = $urandom();

      chk("rnd_align", 32'(bus.align_err), 32'(exp_al));
      if (bus.imem_req) chk("rnd_addr_lsb", 32'(bus.imem_addr[1:0]), 32'd0);
      if (p_req && !p_ack) begin
        chk("rnd_req_held", 32'(bus.imem_req), 32'd1);
        chk("rnd_addr_held", bus.imem_addr, p_addr);
      end
      if (p_valid && !p_rdy && !p_eff) begin
        chk("rnd_valid_held", 32'(bus.inst_valid), 32'd1);
        chk("rnd_inst_held", bus.inst, p_inst);
        chk("rnd_ipc_held", bus.inst_pc, p_ipc);
      end

      eff = bus.redir_valid && (bus.npc_op >= 4'd1) && (bus.npc_op <= 4'd4);
      if (bus.inst_valid && bus.inst_ready && !eff) begin
        chk("rnd_ipc", bus.inst_pc, exp_pc);
        chk("rnd_inst", bus.inst, mem_data(bus.inst_pc));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (eff) exp_pc = ref_target(bus.npc_op, bus.redir_pc, bus.imm16, bus.imm26, bus.rs_data);
      exp_al = bus.redir_valid && (bus.npc_op == 4'd3 || bus.npc_op == 4'd4) && (bus.rs_data[1:0] != 2'b00);

      p_req   = bus.imem_req;
      p_ack   = bus.imem_ack;
      p_addr  = bus.imem_addr;
      p_valid = bus.inst_valid;
      p_rdy   = bus.inst_ready;
      p_eff   = eff;
      p_inst  = bus.inst;
      p_ipc   = bus.inst_pc;
    end
    chk("rnd_progress", 32'(consumed > 100), 32'd1);
    rand_lat = 1'b0;
    mem_lat  = 1;
    idle_inputs();
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    cyc();
    chk_reset_outputs("reset");
    do_reset();
    chk_reset_outputs("reset_release");
    seq_basic();
    seq_stall();
    seq_table();
    seq_jr_late();
    seq_reset_mid();
    seq_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
